// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
// Holds funct3 op codes, FSM states, iteration count and special-case results.
// No logic beyond a small decode helper.
package muldiv_pkg;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         ITERATIONS = 32;
    localparam logic [5:0] ITER_LAST  = 6'(ITERATIONS - 1);

    localparam logic [31:0] QUOT_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // REM and REMU both have funct3 = 11x
    function automatic logic is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation (magnitude conversion / sign fix-up).
// Latency: purely combinational.
// Backpressure: none, no state.
module muldiv_negate #(
    parameter int W = 64
) (
    input  logic         en,
    input  logic [W-1:0] val,
    output logic [W-1:0] res
);

    assign res = en ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: 33 cycles start-to-done for normal ops, 1 cycle for special cases.
// Backpressure: busy high while iterating; start ignored unless IDLE. Divider built only with MULDIV_DIV_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int W2 = 2 * XLEN;

    state_t          state, state_next;
    logic [5:0]      cnt;
    logic [2:0]      op;
    logic            neg;
    logic [XLEN-1:0] opnd;   // multiplicand for MUL*, divisor for DIV*
    logic [W2-1:0]   acc;    // MUL*: {partial product, multiplier}; DIV*: quotient in low half

    logic            is_div, a_signed, b_signed, sign_a, sign_b, neg_in;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            special;
    logic [XLEN-1:0] special_res;

    logic [XLEN:0]   mul_sum;
    logic [W2-1:0]   step_acc;
    logic [W2-1:0]   fin_val, fin_corr;
    logic [XLEN-1:0] fin_res;

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] step_rem;
    logic [XLEN:0]   part_rem, trial;
`endif

    // Operand signedness and the sign the final result must carry
    always_comb begin
        is_div   = funct3[2];
        a_signed = funct3 inside {F_MUL, F_MULH, F_MULHSU, F_DIV, F_REM};
        b_signed = funct3 inside {F_MUL, F_MULH, F_DIV, F_REM};
        sign_a   = a_signed & op_a[XLEN-1];
        sign_b   = b_signed & op_b[XLEN-1];
        neg_in   = is_rem(funct3) ? sign_a : (sign_a ^ sign_b);
    end

    muldiv_negate #(.W(XLEN)) u_abs_a (.en(sign_a), .val(op_a), .res(abs_a));
    muldiv_negate #(.W(XLEN)) u_abs_b (.en(sign_b), .val(op_b), .res(abs_b));

    // Ops whose result is known at accept time and bypass the iteration
    always_comb begin
        special     = 1'b0;
        special_res = '0;
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            if (op_b == '0) begin
                special     = 1'b1;
                special_res = funct3[1] ? op_a : QUOT_ALL_ONES;
            end else if (!funct3[0] && op_a == INT_MIN && op_b == QUOT_ALL_ONES) begin
                special     = 1'b1;
                special_res = funct3[1] ? '0 : INT_MIN;
            end
        end
`else
        if (is_div) begin
            special = 1'b1;
        end
`endif
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        step_acc = {mul_sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        part_rem = {rem, acc[XLEN-1]};
        trial    = part_rem - {1'b0, opnd};
        step_rem = part_rem[XLEN-1:0];
        if (op[2]) begin
            if (!trial[XLEN]) begin
                step_rem = trial[XLEN-1:0];
                step_acc = {acc[W2-1:XLEN], acc[XLEN-2:0], 1'b1};
            end else begin
                step_acc = {acc[W2-1:XLEN], acc[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    // Select the raw magnitude produced by the final iteration
    always_comb begin
        fin_val = step_acc;
`ifdef MULDIV_DIV_EN
        if (op[2]) begin
            fin_val = is_rem(op) ? {{XLEN{1'b0}}, step_rem} : {{XLEN{1'b0}}, step_acc[XLEN-1:0]};
        end
`endif
    end

    muldiv_negate #(.W(W2)) u_fix (.en(neg), .val(fin_val), .res(fin_corr));

    // MUL and divides return the low word, MULH* the high word of the corrected product
    always_comb begin
        fin_res = (op == F_MUL || op[2]) ? fin_corr[XLEN-1:0] : fin_corr[W2-1:XLEN];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == ITER_LAST) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            op     <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            result <= '0;
`ifdef MULDIV_DIV_EN
            rem    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op  <= funct3;
                        neg <= neg_in;
                        cnt <= '0;
                        if (special) begin
                            result <= special_res;
                        end else begin
                            opnd <= is_div ? abs_b : abs_a;
                            acc  <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
`ifdef MULDIV_DIV_EN
                            rem  <= '0;
`endif
                        end
                    end
                end
                ST_CALC: begin
                    acc <= step_acc;
`ifdef MULDIV_DIV_EN
                    rem <= step_rem;
`endif
                    if (cnt == ITER_LAST) begin
                        cnt    <= '0;
                        result <= fin_res;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a reference model,
// reset abort and ignored-start sequences. Results scored through an expectation queue.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
        logic        poke;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          id;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int  nvec = 0;
    int  nerr = 0;
    int  next_id = 0;
    sb_t exp_q[$];
    sb_t mon_e;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f)
            F_MUL:    begin p = sa * sb; r = p[31:0];  end
            F_MULH:   begin p = sa * sb; r = p[63:32]; end
            F_MULHSU: begin p = sa * ub; r = p[63:32]; end
            F_MULHU:  begin p = ua * ub; r = p[63:32]; end
            F_DIV: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == INT_MIN && b == 32'hFFFF_FFFF) r = INT_MIN;
                else begin p = sa / sb; r = p[31:0]; end
            end
            F_DIVU: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            F_REM: begin
                if (b == 0) r = a;
                else if (a == INT_MIN && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    // Score every done pulse against the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("op%0d result", mon_e.id), result, mon_e.exp);
            end
        end
    end

    task automatic issue(input vec_t v);
        logic [31:0] exp;
        logic        spec;
        int          k, busy_cnt, done_at;
        sb_t         e;
        exp  = v.exp;
        spec = v.special;
`ifndef MULDIV_DIV_EN
        if (v.f3[2]) begin
            exp  = '0;
            spec = 1'b1;
        end
`endif
        @(negedge clk);
        start  = 1'b1;
        funct3 = v.f3;
        op_a   = v.a;
        op_b   = v.b;
        e.exp  = exp;
        e.id   = next_id;
        exp_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        busy_cnt = 0;
        done_at  = 0;
        while (done_at == 0 && k <= 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_at = k;
            end else begin
                if (v.poke && k == 5) begin
                    start  = 1'b1;
                    funct3 = F_MULHU;
                    op_a   = 32'hFFFF_FFFF;
                    op_b   = 32'hFFFF_FFFF;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        check($sformatf("op%0d done cycle", next_id), 32'(done_at), spec ? 32'd1 : 32'd33);
        check($sformatf("op%0d busy cycles", next_id), 32'(busy_cnt), spec ? 32'd0 : 32'd32);
        next_id++;
    endtask

    initial begin
        vec_t        tbl [18];
        vec_t        rv;
        logic [31:0] ra, rb;
        logic [2:0]  rf;

        reset  = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        tbl = '{
            '{F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1},
            '{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0},
            '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0},
            '{F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0},
            '{F_MULHU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0},
            '{F_MUL,    32'h0001_0000, 32'h0001_0000, 32'd0,         1'b0, 1'b0},
            '{F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0},
            '{F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0},
            '{F_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 1'b0},
            '{F_REMU,   32'd100,       32'd7,         32'd2,         1'b0, 1'b0},
            '{F_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0},
            '{F_DIV,    32'd10,        32'd2,         32'd5,         1'b0, 1'b0},
            '{F_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0},
            '{F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 1'b0},
            '{F_REMU,   32'd5,         32'd0,         32'd5,         1'b1, 1'b0},
            '{F_REM,    32'd5,         32'd0,         32'd5,         1'b1, 1'b0},
            '{F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0},
            '{F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0}
        };
        for (int i = 0; i < 18; i++) issue(tbl[i]);

        for (int i = 0; i < 20; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rv.f3      = rf;
            rv.a       = ra;
            rv.b       = rb;
            rv.exp     = ref_model(rf, ra, rb);
            rv.special = rf[2] && (rb == 0 || (!rf[0] && ra == INT_MIN && rb == 32'hFFFF_FFFF));
            rv.poke    = 1'b0;
            issue(rv);
        end

        // Abort a long op with reset ten cycles in; nothing may complete
        @(negedge clk);
        start = 1'b1;
        op_a  = 32'd1000;
        op_b  = 32'd7;
`ifdef MULDIV_DIV_EN
        funct3 = F_DIVU;
`else
        funct3 = F_MULHU;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy before reset", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        check("abort still idle", 32'(busy), 32'd0);
        reset = 1'b0;

        rv = '{F_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0};
        issue(rv);

        repeat (40) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
